// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator: per-channel periodic/one-shot ticks plus a divided square wave.
// All outputs registered, one cycle after the deciding edge; no backpressure, load always wins over counting.
module tick_gen_multi #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] div_in,
    input  logic [CHANNELS-1:0]       oneshot,
    input  logic [CHANNELS-1:0]       en,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       sq,
    output logic [CHANNELS-1:0]       done,
    output logic [CHANNELS-1:0]       active
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] tc;
        logic             mode;
        logic             armed;
        logic             tick_r;
        logic             sq_r;
        logic             done_r;
        logic             at_tc;

        // The compare, not overflow, returns cnt to zero, so tc = all-ones gives a full 2^WIDTH period.
        assign at_tc = (cnt == tc);

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt    <= '0;
                tc     <= '0;
                mode   <= 1'b0;
                armed  <= 1'b0;
                tick_r <= 1'b0;
                sq_r   <= 1'b0;
                done_r <= 1'b0;
            end else if (load[i]) begin
                tc     <= div_in[i*WIDTH +: WIDTH];
                mode   <= oneshot[i];
                cnt    <= '0;
                armed  <= 1'b1;
                done_r <= 1'b0;
                tick_r <= 1'b0;
            end else if (armed && en[i]) begin
                if (at_tc) begin
                    cnt    <= '0;
                    tick_r <= 1'b1;
                    sq_r   <= ~sq_r;
                    if (mode) begin
                        armed  <= 1'b0;
                        done_r <= 1'b1;
                    end
                end else begin
                    cnt    <= cnt + 1'b1;
                    tick_r <= 1'b0;
                end
            end else begin
                tick_r <= 1'b0;
            end
        end

        assign tick[i]   = tick_r;
        assign sq[i]     = sq_r;
        assign done[i]   = done_r;
        assign active[i] = armed;
    end

endmodule

// File: doc/tick_gen_multi.md
Name: tick_gen_multi

Overview:
Parametrised multi-channel programmable tick generator. Successor to the single-channel fixed-compare divider in the stopwatch/timer datapath. Each channel takes a runtime-loadable terminal count and produces single-cycle tick pulses and a divided square wave. Channels run periodic or one-shot, can be paused, and are independent of each other. Ticks drive the stopwatch digit counters, display multiplexing and debounce sampling.

Parameters:
CHANNELS, 4, number of independent tick channels (1..16)
WIDTH, 32, terminal-count and counter width per channel (2..63)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high; clears all channel state
load  in  CHANNELS  per-channel: latch new terminal count, restart channel
div_in  in  CHANNELS*WIDTH  terminal counts; channel i uses bits [i*WIDTH +: WIDTH]
oneshot  in  CHANNELS  mode sampled at load: 1 = one-shot, 0 = periodic
en  in  CHANNELS  per-channel count enable (pause when 0)
tick  out  CHANNELS  registered single-cycle pulse at each terminal count
sq  out  CHANNELS  registered square wave; toggles on every tick
done  out  CHANNELS  sticky; one-shot channel has fired
active  out  CHANNELS  channel armed and counting (not idle or done)

Behaviour:
- Per-channel state: cnt[WIDTH], tc[WIDTH], mode bit, armed bit, plus registered tick, sq and done. All outputs are registered.
- Reset (sync, highest priority): cnt=0, tc=0, mode=0, armed=0, tick=0, sq=0, done=0, active=0. A channel stays idle after reset until its first load.
- Load (priority over en and over any tick in that cycle):
  - Next cycle: tc=div_in slice, mode=oneshot[i], cnt=0, armed=1, done=0, tick=0.
  - sq is unchanged.
  - The terminal-count event in the load cycle is discarded.
- Counting happens when armed=1 and en=1:
  - If cnt==tc: cnt<=0 and tick<=1 next cycle, else cnt<=cnt+1 and tick<=0.
  - With en held high, tick fires every tc+1 cycles.
  - The first tick after load appears on the clock edge ending cycle tc+1 after the load edge: load at edge 0 gives tick high in the cycle after edge tc+1.
- tc=0: tick is high every cycle while enabled; sq toggles every cycle (clk/2).
- tc=2^WIDTH-1: period is 2^WIDTH cycles. cnt never wraps through its overflow path; the compare resets it.
- Pause (en=0 while armed): cnt and sq hold, tick=0. Resume continues from the held cnt, so no phase is lost.
- sq: toggles on every cycle in which tick is registered high. Period is 2*(tc+1) cycles, 50% duty.
- One-shot (mode=1):
  - On the terminal event: tick pulses once, sq toggles once, armed<=0 and done<=1 in the same edge.
  - Further en has no effect until the next load.
  - done stays high until load or reset.
- active = armed. It is low after reset, high the cycle after load, and low from the edge that sets done.
- Load while a one-shot is mid-count: restarts cleanly with the new tc. done stays 0.
- Load with oneshot=0 on a done channel: re-arms it as periodic.
- Channels are fully independent. Simultaneous loads and ticks on different channels do not interact.
- No combinational path from any input to any output.

Test Plan:
- Reset, then load ch0 with tc=4, periodic, en=1 held -> tick[0] pulses exactly every 5 cycles, first pulse 5 cycles after load edge; sq[0] period 10 cycles; no ticks on unloaded channels.
- ch1 tc=0 periodic, en=1 -> tick[1] high every cycle, sq[1]=clk/2; then drop en for 3 cycles -> tick[1]=0, sq[1] holds; resume -> ticks resume the next cycle.
- ch2 tc=9, en toggled 1-0-1 with 4 low cycles mid-count -> first tick arrives 14 cycles after load (10 enabled + 4 paused); phase preserved.
- ch3 oneshot=1 tc=3 -> single tick 4 cycles after load, done[3]=1 and active[3]=0 thereafter for 50 cycles with en=1; reload with tc=1 -> done clears, one tick after 2 cycles.
- Load ch0 on the exact cycle cnt==tc (tc=4 -> new tc=7) -> that tick is suppressed, next tick 8 cycles later; assert reset mid-count on all channels -> all outputs 0 the next cycle, no ticks until reload.
- WIDTH=4 build, tc=15 -> period 16 cycles, no wrap glitch; CHANNELS=1 build elaborates and passes scenario 1.
